spectrum_peak_picker: RTL and testbench



---
 rtl/spectrum_peak_picker_pkg.sv | 19 +
 rtl/spectrum_peak_picker_if.sv | 28 ++
 rtl/spectrum_peak_picker_insert.sv | 41 ++++
 rtl/spectrum_peak_picker.sv | 108 ++++++++++
 tb/tb_spectrum_peak_picker.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/spectrum_peak_picker_pkg.sv
// rtl/spectrum_peak_picker_pkg.sv - shared widths, peak entry type and FSM states for the peak picker
package spectrum_pkg;
    localparam int BIN_W     = 10;
    localparam int MAG_W     = 32;
    localparam int NORM_W    = 21;
    localparam int NORM_SQ_W = 42;

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic [BIN_W-1:0] bin;
    } peak_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SQUARE,
        ST_COMPARE,
        ST_EMIT
    } pp_state_t;
endpackage

// File: rtl/spectrum_peak_picker_if.sv
// rtl/spectrum_peak_picker_if.sv - bin stream, norm strobe and per-frame peak result bundle
interface spectrum_peak_picker_if #(
    parameter int NUM_PEAKS = 3
);
    import spectrum_pkg::*;

    logic [MAG_W-1:0]           mag_squared_tdata;
    logic                       mag_squared_tlast;
    logic [11:0]                mag_squared_tuser;
    logic                       mag_squared_tvalid;
    logic [NORM_W-1:0]          norm_tdata;
    logic                       norm_tvalid;
    logic [BIN_W*NUM_PEAKS-1:0] peak_bins;
    logic [NUM_PEAKS-1:0]       peak_hit;
    logic                       peaks_tvalid;

    modport master (
        output mag_squared_tdata, mag_squared_tlast, mag_squared_tuser, mag_squared_tvalid,
        output norm_tdata, norm_tvalid,
        input  peak_bins, peak_hit, peaks_tvalid
    );

    modport slave (
        input  mag_squared_tdata, mag_squared_tlast, mag_squared_tuser, mag_squared_tvalid,
        input  norm_tdata, norm_tvalid,
        output peak_bins, peak_hit, peaks_tvalid
    );
endinterface

// File: rtl/spectrum_peak_picker_insert.sv
// rtl/spectrum_peak_picker_insert.sv - descending-sorted top-N register list with insert and clear
module peak_insert_list
    import spectrum_pkg::*;
#(
    parameter int NUM_PEAKS = 3
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  insert,
    input  peak_t ins_peak,
    output peak_t list_next [NUM_PEAKS]
);
    peak_t                list_q [NUM_PEAKS];
    logic [NUM_PEAKS-1:0] gt;

    // The list is sorted, so gt is thermometer-shaped: the first set bit is the insert slot.
    always_comb begin
        gt = '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            gt[i] = insert && (ins_peak.mag > list_q[i].mag);
        end
    end

    always_comb begin
        list_next[0] = gt[0] ? ins_peak : list_q[0];
        for (int j = 1; j < NUM_PEAKS; j++) begin
            list_next[j] = !gt[j] ? list_q[j] : (gt[j-1] ? list_q[j-1] : ins_peak);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PEAKS; i++) list_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_PEAKS; i++) list_q[i] <= '0;
        end else begin
            list_q <= list_next;
        end
    end
endmodule

// File: rtl/spectrum_peak_picker.sv
// rtl/spectrum_peak_picker.sv - per-frame top-N in-band peak tracker with norm-relative qualification
module spectrum_peak_picker
    import spectrum_pkg::*;
#(
    parameter int NUM_PEAKS    = 3,
    parameter int BIN_LO       = 73,
    parameter int BIN_HI       = 1023,
    parameter int THRESH_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spectrum_peak_picker_if.slave  bus
);
    pp_state_t                  state_q, state_d;
    peak_t                      list_next [NUM_PEAKS];
    peak_t                      held_q    [NUM_PEAKS];
    peak_t                      work_q    [NUM_PEAKS];
    logic                       pending_q;
    logic [NORM_W-1:0]          norm_q;
    logic [NORM_SQ_W-1:0]       norm_sq_q;
    logic [NUM_PEAKS-1:0]       hit_q;
    logic [BIN_W*NUM_PEAKS-1:0] peak_bins_q;
    logic [NUM_PEAKS-1:0]       peak_hit_q;
    logic                       peaks_tvalid_q;

    logic  eligible, tlast_beat, norm_accept;
    peak_t ins_peak;

    assign eligible   = bus.mag_squared_tvalid
                     && (bus.mag_squared_tuser[11:10] == 2'b00)
                     && (bus.mag_squared_tuser >= 12'(BIN_LO))
                     && (bus.mag_squared_tuser <= 12'(BIN_HI))
                     && (bus.mag_squared_tdata != '0);
    assign tlast_beat  = bus.mag_squared_tvalid && bus.mag_squared_tlast;
    assign norm_accept = (state_q == ST_IDLE) && bus.norm_tvalid && pending_q;
    assign ins_peak    = '{mag: bus.mag_squared_tdata, bin: bus.mag_squared_tuser[BIN_W-1:0]};

    peak_insert_list #(.NUM_PEAKS(NUM_PEAKS)) u_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tlast_beat),
        .insert    (eligible),
        .ins_peak  (ins_peak),
        .list_next (list_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (norm_accept) state_d = ST_SQUARE;
            ST_SQUARE:  state_d = ST_COMPARE;
            ST_COMPARE: state_d = ST_EMIT;
            ST_EMIT:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PEAKS; i++) begin
                held_q[i] <= '0;
                work_q[i] <= '0;
            end
            pending_q      <= 1'b0;
            norm_q         <= '0;
            norm_sq_q      <= '0;
            hit_q          <= '0;
            peak_bins_q    <= '0;
            peak_hit_q     <= '0;
            peaks_tvalid_q <= 1'b0;
        end else begin
            // A new tlast wins over consumption so a same-edge frame stays pending.
            if (tlast_beat) held_q <= list_next;
            if (norm_accept) begin
                work_q <= held_q;
                norm_q <= bus.norm_tdata;
            end
            pending_q <= tlast_beat ? 1'b1 : (norm_accept ? 1'b0 : pending_q);

            if (state_q == ST_SQUARE) begin
                norm_sq_q <= NORM_SQ_W'(norm_q) * NORM_SQ_W'(norm_q);
            end
            if (state_q == ST_COMPARE) begin
                for (int i = 0; i < NUM_PEAKS; i++) begin
                    hit_q[i] <= (work_q[i].mag != '0)
                             && ((48'(work_q[i].mag) << THRESH_SHIFT) >= 48'(norm_sq_q));
                end
            end

            peaks_tvalid_q <= (state_q == ST_EMIT);
            if (state_q == ST_EMIT) begin
                for (int i = 0; i < NUM_PEAKS; i++) begin
                    peak_bins_q[BIN_W*i +: BIN_W] <= work_q[i].bin;
                end
                peak_hit_q <= hit_q;
            end
        end
    end

    assign bus.peak_bins    = peak_bins_q;
    assign bus.peak_hit     = peak_hit_q;
    assign bus.peaks_tvalid = peaks_tvalid_q;
endmodule

// File: tb/tb_spectrum_peak_picker.sv
// tb/tb_spectrum_peak_picker.sv - directed-vector self-checking bench for spectrum_peak_picker
module tb_spectrum_peak_picker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    spectrum_peak_picker_if #(.NUM_PEAKS(3)) bus ();

    spectrum_peak_picker #(
        .NUM_PEAKS(3), .BIN_LO(73), .BIN_HI(1023), .THRESH_SHIFT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int bin, input int mag, input bit last);
        @(negedge clk);
        bus.mag_squared_tvalid = 1'b1;
        bus.mag_squared_tuser  = 12'(bin);
        bus.mag_squared_tdata  = 32'(mag);
        bus.mag_squared_tlast  = last;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.mag_squared_tvalid = 1'b0;
        bus.mag_squared_tlast  = 1'b0;
        bus.mag_squared_tdata  = '0;
        bus.mag_squared_tuser  = '0;
    endtask

    // Norm accepted at edge T; result must appear in the cycle after T+3 exactly once.
    task automatic run_norm(input string tag, input int norm, input bit expect_emit,
                            input logic [29:0] exp_bins, input logic [2:0] exp_hit);
        int first;
        int cnt;
        first = 0;
        cnt   = 0;
        @(negedge clk);
        bus.norm_tvalid = 1'b1;
        bus.norm_tdata  = 21'(norm);
        @(negedge clk);
        bus.norm_tvalid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.peaks_tvalid) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        if (expect_emit) begin
            chk({tag, "_latency"}, 64'(first), 64'd3);
            chk({tag, "_pulses"}, 64'(cnt), 64'd1);
        end else begin
            chk({tag, "_no_emit"}, 64'(cnt), 64'd0);
        end
        chk({tag, "_bins"}, 64'(bus.peak_bins), 64'(exp_bins));
        chk({tag, "_hit"}, 64'(bus.peak_hit), 64'(exp_hit));
    endtask

    task automatic frame_a();
        beat(100, 500, 0);
        beat(200, 900, 0);
        beat(300, 700, 0);
        beat(1023, 0, 1);
        idle();
    endtask

    initial begin
        bus.mag_squared_tvalid = 1'b0;
        bus.mag_squared_tlast  = 1'b0;
        bus.mag_squared_tdata  = '0;
        bus.mag_squared_tuser  = '0;
        bus.norm_tvalid        = 1'b0;
        bus.norm_tdata         = '0;
        repeat (3) @(negedge clk);
        chk("rst_bins", 64'(bus.peak_bins), 64'd0);
        chk("rst_hit", 64'(bus.peak_hit), 64'd0);
        chk("rst_tvalid", 64'(bus.peaks_tvalid), 64'd0);
        rst_n = 1'b1;

        frame_a();
        run_norm("a_n30", 30, 1, {10'd100, 10'd300, 10'd200}, 3'b111);
        frame_a();
        run_norm("a_n100", 100, 1, {10'd100, 10'd300, 10'd200}, 3'b011);

        // Out-of-band bins, the BIN_LO edge and a threshold just below norm^2 = 49.
        beat(50, 32'h7fff_0000, 0);
        beat(72, 1000, 0);
        beat(73, 3, 0);
        beat(80, 10, 0);
        beat(1100, 32'h7fff_0000, 0);
        beat(1023, 0, 1);
        idle();
        run_norm("band", 7, 1, {10'd0, 10'd73, 10'd80}, 3'b001);

        beat(150, 400, 0);
        beat(160, 400, 0);
        beat(1023, 5, 1);
        idle();
        run_norm("tie", 1, 1, {10'd1023, 10'd160, 10'd150}, 3'b111);

        beat(100, 500, 0);
        beat(1023, 0, 1);
        beat(400, 77, 0);
        beat(1023, 0, 1);
        idle();
        run_norm("two_frames", 1, 1, {10'd0, 10'd0, 10'd400}, 3'b001);
        run_norm("no_pending", 1, 0, {10'd0, 10'd0, 10'd400}, 3'b001);

        beat(500, 9999, 0);
        beat(600, 8888, 0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.mag_squared_tvalid = 1'b0;
        #1;
        chk("midrst_bins", 64'(bus.peak_bins), 64'd0);
        chk("midrst_hit", 64'(bus.peak_hit), 64'd0);
        chk("midrst_tvalid", 64'(bus.peaks_tvalid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beat(700, 300, 0);
        beat(800, 200, 0);
        beat(900, 100, 1);
        idle();
        run_norm("post_rst", 10, 1, {10'd900, 10'd800, 10'd700}, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
